// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises word/half/byte data requests and instruction fetches onto a byte-wide RAM bus.
// Optional feature macro MEM_CTRL_IO_STALL_EN: IO-region store bytes wait while io_buffer_full is high.
module mem_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear_up,
  input  logic              lsb_visit_mem,
  input  logic [6:0]        op_type_out,
  input  logic [2:0]        op_out,
  input  logic [ADDR_W-1:0] store_addr_out,
  input  logic [31:0]       store_val_in,
  output logic              cache_welcome_signal,
  output logic              cache_ready,
  output logic              is_load,
  output logic [31:0]       load_val_out,
  input  logic              ifetch_req,
  input  logic [ADDR_W-1:0] ifetch_addr,
  output logic              ifetch_ready,
  output logic [31:0]       ifetch_inst,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  localparam logic [6:0] LD_TYPE = 7'b0000011;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  logic        w_welcome;
  logic        w_reqIsLoad;
  logic        w_acceptLsb;
  logic        w_acceptFetch;
  logic [31:0] w_lsbAddr;
  logic [31:0] w_fetchAddr;
  logic [31:0] w_nextAddr;
  logic [31:0] w_assembled;
  logic [31:0] w_extended;
  logic [2:0]  w_len;
  logic [2:0]  w_cntInc;
  logic        w_lastRead;
  logic        w_lastWrite;
  logic [1:0]  w_capIdx;
  logic [1:0]  w_nextIdx;
  logic [7:0]  w_nextByte;
  logic        w_stallAccept;
  logic        w_stallNext;
  logic        w_stallHold;

  assign w_lsbAddr   = 32'(store_addr_out);
  assign w_fetchAddr = 32'(ifetch_addr);

`ifdef MEM_CTRL_IO_STALL_EN
  // Each IO byte is checked at the edge that would start driving it.
  assign w_stallAccept = (w_lsbAddr[17:16] == IO_HI) && io_buffer_full;
  assign w_stallNext   = (w_nextAddr[17:16] == IO_HI) && io_buffer_full;
  assign w_stallHold   = (mem_a[17:16] == IO_HI) && io_buffer_full;
`else
  logic w_unusedIo;
  assign w_unusedIo    = &{1'b0, io_buffer_full, IO_HI};
  assign w_stallAccept = 1'b0;
  assign w_stallNext   = 1'b0;
  assign w_stallHold   = 1'b0;
`endif

  always_comb begin
    unique case (r_op[1:0])
      2'd0:    w_len = 3'd1;
      2'd1:    w_len = 3'd2;
      default: w_len = 3'd4;
    endcase
  end

  assign w_cntInc    = r_cnt + 3'd1;
  assign w_nextAddr  = r_addr + {29'd0, w_cntInc};
  assign w_lastRead  = (r_cnt == w_len);
  assign w_lastWrite = (w_cntInc == w_len);
  assign w_capIdx    = 2'(r_cnt - 3'd1);
  assign w_nextIdx   = w_cntInc[1:0];
  assign w_nextByte  = r_data[{w_nextIdx, 3'b000} +: 8];

  // mem_din lags mem_a by one cycle, so the byte arriving now belongs to index cnt-1.
  always_comb begin
    w_assembled = r_data;
    if (r_cnt != 3'd0) begin
      w_assembled[{w_capIdx, 3'b000} +: 8] = mem_din;
    end
  end

  always_comb begin
    unique case (r_op)
      3'd0:    w_extended = {{24{w_assembled[7]}}, w_assembled[7:0]};
      3'd1:    w_extended = {{16{w_assembled[15]}}, w_assembled[15:0]};
      3'd4:    w_extended = {24'd0, w_assembled[7:0]};
      3'd5:    w_extended = {16'd0, w_assembled[15:0]};
      default: w_extended = w_assembled;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else if (rdy_in) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acceptLsb) begin
          w_nextState = w_reqIsLoad ? LOAD : STORE;
        end else if (w_acceptFetch) begin
          w_nextState = FETCH;
        end
      end
      LOAD, FETCH: begin
        if (rob_clear_up || w_lastRead) begin
          w_nextState = IDLE;
        end
      end
      STORE: begin
        if (mem_wr && w_lastWrite) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Pending ready pulses keep welcome low so a still-held request is not taken twice.
  always_comb begin
    w_welcome            = (r_state == IDLE) && !cache_ready && !ifetch_ready;
    w_reqIsLoad          = (op_type_out == LD_TYPE);
    w_acceptLsb          = rdy_in && w_welcome && !rob_clear_up && lsb_visit_mem;
    w_acceptFetch        = rdy_in && w_welcome && !rob_clear_up && !lsb_visit_mem && ifetch_req;
    cache_welcome_signal = w_welcome;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt        <= 3'd0;
      r_op         <= 3'd0;
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      cache_ready  <= 1'b0;
      is_load      <= 1'b0;
      load_val_out <= 32'd0;
      ifetch_ready <= 1'b0;
      ifetch_inst  <= 32'd0;
      mem_a        <= 32'd0;
      mem_dout     <= 8'd0;
      mem_wr       <= 1'b0;
    end else if (rdy_in) begin
      cache_ready  <= 1'b0;
      ifetch_ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_acceptLsb) begin
            r_addr   <= w_lsbAddr;
            r_data   <= store_val_in;
            r_op     <= op_out;
            r_cnt    <= 3'd0;
            mem_a    <= w_lsbAddr;
            mem_dout <= store_val_in[7:0];
            mem_wr   <= !w_reqIsLoad && !w_stallAccept;
          end else if (w_acceptFetch) begin
            r_addr <= w_fetchAddr;
            r_data <= 32'd0;
            r_op   <= 3'd2;
            r_cnt  <= 3'd0;
            mem_a  <= w_fetchAddr;
            mem_wr <= 1'b0;
          end
        end
        LOAD, FETCH: begin
          if (!rob_clear_up) begin
            mem_a  <= w_nextAddr;
            r_data <= w_assembled;
            r_cnt  <= w_cntInc;
            if (w_lastRead) begin
              if (r_state == LOAD) begin
                cache_ready  <= 1'b1;
                is_load      <= 1'b1;
                load_val_out <= w_extended;
              end else begin
                ifetch_ready <= 1'b1;
                ifetch_inst  <= w_assembled;
              end
            end
          end
        end
        STORE: begin
          if (!mem_wr) begin
            mem_wr <= !w_stallHold;
          end else if (w_lastWrite) begin
            mem_wr       <= 1'b0;
            cache_ready  <= 1'b1;
            is_load      <= 1'b0;
            load_val_out <= 32'd0;
          end else begin
            mem_a    <= w_nextAddr;
            mem_dout <= w_nextByte;
            r_cnt    <= w_cntInc;
            mem_wr   <= !w_stallNext;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
